// File: rtl/pa_result_drain.sv
// pa_result_drain
//
// Result-drain stage between the processor-array PEs and the result sink.
// On a capture pulse it snapshots the whole SIZE_MAT x SIZE_MAT result array
// in one cycle. It then streams the snapshot out LANES elements per beat over
// a valid/ready handshake, in row or column order.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   capture_i      pulse: snapshot cap_data_i (ignored and flagged while busy)
//   transpose_i    order select sampled with capture_i (0 row, 1 column)
//   cap_data_i     flattened PE results, element e at [e*WIDTH_DATA +: WIDTH_DATA]
//   out_ready_i    sink ready
//   out_valid_o    beat valid
//   out_data_o     beat data, lane 0 in the LSBs
//   out_last_o     final beat of the snapshot (qualified by out_valid_o)
//   busy_o         snapshot held / draining
//   overrun_o      sticky: a capture was dropped because the stage was busy
//   clr_overrun_i  clears overrun_o (a new overrun in the same cycle wins)

module pa_result_drain #(
   parameter int SIZE_MAT   = 16,
   parameter int WIDTH_DATA = 16,
   parameter int LANES      = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   capture_i,
   input  logic                                   transpose_i,
   input  logic [SIZE_MAT*SIZE_MAT*WIDTH_DATA-1:0] cap_data_i,
   input  logic                                   out_ready_i,
   output logic                                   out_valid_o,
   output logic [LANES*WIDTH_DATA-1:0]            out_data_o,
   output logic                                   out_last_o,
   output logic                                   busy_o,
   output logic                                   overrun_o,
   input  logic                                   clr_overrun_i
);

   localparam int N      = SIZE_MAT * SIZE_MAT;
   localparam int NBEATS = N / LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int BEATW  = LANES * WIDTH_DATA;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   if ((N % LANES) != 0) begin : g_laneCheck
      $error("pa_result_drain: SIZE_MAT*SIZE_MAT must be a multiple of LANES");
   end

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t                         r_state;
   logic [BW-1:0]                  r_beat;
   logic [NBEATS-1:0][BEATW-1:0]   r_buf;
   logic                           r_overrun;

   logic [NBEATS-1:0][BEATW-1:0]   w_capBuf;
   logic                           w_drain;
   logic                           w_xfer;
   logic                           w_lastBeat;
   logic                           w_lastXfer;
   logic                           w_overSet;

   // The snapshot is reordered into stream order while it is captured. The
   // permutation is pure wiring selected by transpose_i, so the drain side only
   // has to walk the buffer one beat at a time.
   always_comb begin
      w_capBuf = '0;
      for (int s = 0; s < N; s++) begin
         if (transpose_i) begin
            w_capBuf[s / LANES][(s % LANES)*WIDTH_DATA +: WIDTH_DATA] =
               cap_data_i[((s % SIZE_MAT)*SIZE_MAT + s / SIZE_MAT)*WIDTH_DATA +: WIDTH_DATA];
         end else begin
            w_capBuf[s / LANES][(s % LANES)*WIDTH_DATA +: WIDTH_DATA] =
               cap_data_i[s*WIDTH_DATA +: WIDTH_DATA];
         end
      end
   end

   assign w_drain    = (r_state == DRAIN);
   assign w_xfer     = w_drain & out_ready_i;
   assign w_lastBeat = (r_beat == LAST_BEAT);
   assign w_lastXfer = w_xfer & w_lastBeat;
   // A capture is accepted only while idle or on the cycle the last beat leaves.
   assign w_overSet  = w_drain & capture_i & ~w_lastXfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_buf     <= '0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (capture_i) begin
                  r_buf   <= w_capBuf;
                  r_beat  <= '0;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_xfer) begin
                  if (!w_lastBeat) begin
                     r_beat <= r_beat + BW'(1);
                  end else if (capture_i) begin
                     // Back-to-back snapshot: no idle bubble between streams.
                     r_buf  <= w_capBuf;
                     r_beat <= '0;
                  end else begin
                     r_beat  <= '0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (w_overSet) begin
            r_overrun <= 1'b1;
         end else if (clr_overrun_i) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign out_valid_o = w_drain;
   assign busy_o      = w_drain;
   assign out_last_o  = w_drain & w_lastBeat;
   assign out_data_o  = r_buf[r_beat];
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_pa_result_drain.sv
// tb_pa_result_drain
//
// Bench for pa_result_drain at SIZE_MAT=4, LANES=2, WIDTH_DATA=16.
// A reference model holds the expected remaining beats of the active snapshot
// in a queue, plus the expected overrun flag. Outputs are compared every cycle
// one time unit after the rising edge. Directed scenarios come first, then a
// randomized run.

module tb_pa_result_drain;

   localparam int SM  = 4;
   localparam int WD  = 16;
   localparam int LN  = 2;
   localparam int N   = SM * SM;
   localparam int NB  = N / LN;

   logic              clk;
   logic              rst_n;
   logic              capture_i;
   logic              transpose_i;
   logic [N*WD-1:0]   cap_data_i;
   logic              out_ready_i;
   logic              out_valid_o;
   logic [LN*WD-1:0]  out_data_o;
   logic              out_last_o;
   logic              busy_o;
   logic              overrun_o;
   logic              clr_overrun_i;

   int compareCount  = 0;
   int mismatchCount = 0;
   int dutXfers      = 0;

   logic [LN*WD-1:0] expQ[$];
   bit               modelOverrun;

   pa_result_drain #(.SIZE_MAT(SM), .WIDTH_DATA(WD), .LANES(LN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .capture_i     (capture_i),
      .transpose_i   (transpose_i),
      .cap_data_i    (cap_data_i),
      .out_ready_i   (out_ready_i),
      .out_valid_o   (out_valid_o),
      .out_data_o    (out_data_o),
      .out_last_o    (out_last_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .clr_overrun_i (clr_overrun_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [N*WD-1:0] makeData(input logic [15:0] base);
      logic [N*WD-1:0] d;
      for (int e = 0; e < N; e++) d[e*WD +: WD] = base + 16'(e);
      return d;
   endfunction

   // Stream index s -> element index, straight from the ordering rule.
   function automatic int streamElem(input int s, input bit tr);
      return tr ? (s % SM) * SM + s / SM : s;
   endfunction

   task automatic loadModel(input logic [N*WD-1:0] d, input bit tr);
      logic [LN*WD-1:0] beat;
      expQ.delete();
      for (int b = 0; b < NB; b++) begin
         for (int l = 0; l < LN; l++)
            beat[l*WD +: WD] = d[streamElem(b*LN + l, tr)*WD +: WD];
         expQ.push_back(beat);
      end
   endtask

   task automatic compareAll();
      checkOutput("valid", 64'(out_valid_o), 64'(expQ.size() > 0));
      checkOutput("busy", 64'(busy_o), 64'(expQ.size() > 0));
      checkOutput("overrun", 64'(overrun_o), 64'(modelOverrun));
      if (expQ.size() > 0) begin
         checkOutput("data", 64'(out_data_o), 64'(expQ[0]));
         checkOutput("last", 64'(out_last_o), 64'(expQ.size() == 1));
      end
   endtask

   // Drives one cycle of inputs, advances the model across the rising edge
   // and compares every output shortly after it.
   task automatic applyStimulus(input bit cap, input bit tr, input bit rdy, input bit clr,
                                input logic [N*WD-1:0] d);
      bit wasValid, xfer, lastXfer, setOvr;
      capture_i     = cap;
      transpose_i   = tr;
      out_ready_i   = rdy;
      clr_overrun_i = clr;
      cap_data_i    = d;
      #1;
      if (out_valid_o && rdy) dutXfers++;
      @(posedge clk);
      wasValid = expQ.size() > 0;
      xfer     = wasValid && rdy;
      lastXfer = xfer && (expQ.size() == 1);
      setOvr   = 1'b0;
      if (xfer) void'(expQ.pop_front());
      if (cap) begin
         if (!wasValid || lastXfer) loadModel(d, tr);
         else setOvr = 1'b1;
      end
      if (setOvr) modelOverrun = 1'b1;
      else if (clr) modelOverrun = 1'b0;
      #1;
      compareAll();
   endtask

   initial begin
      logic [N*WD-1:0] dA;
      logic [N*WD-1:0] dB;
      int guard;

      rst_n = 1'b0;
      capture_i = 0; transpose_i = 0; out_ready_i = 0; clr_overrun_i = 0;
      cap_data_i = '0;
      modelOverrun = 0;
      #2;
      checkOutput("rst_valid", 64'(out_valid_o), 64'd0);
      checkOutput("rst_last", 64'(out_last_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_overrun", 64'(overrun_o), 64'd0);
      checkOutput("rst_data", 64'(out_data_o), 64'd0);
      #10 rst_n = 1'b1;

      dA = makeData(16'h0100);
      dB = makeData(16'h0200);

      $display("[TB] row-order drain");
      applyStimulus(1, 0, 1, 0, dA);
      checkOutput("row_beat0", 64'(out_data_o), 64'h0000_0000_0101_0100);
      for (int i = 0; i < NB; i++) applyStimulus(0, 0, 1, 0, '0);
      applyStimulus(0, 0, 1, 0, '0);

      $display("[TB] column-order drain");
      applyStimulus(1, 1, 1, 0, dA);
      checkOutput("col_beat0", 64'(out_data_o), 64'h0000_0000_0104_0100);
      applyStimulus(0, 0, 1, 0, '0);
      checkOutput("col_beat1", 64'(out_data_o), 64'h0000_0000_010C_0108);
      applyStimulus(0, 0, 1, 0, '0);
      checkOutput("col_beat2", 64'(out_data_o), 64'h0000_0000_0105_0101);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, '0);
      checkOutput("col_beat7", 64'(out_data_o), 64'h0000_0000_010F_010B);
      applyStimulus(0, 0, 1, 0, '0);

      $display("[TB] backpressure");
      applyStimulus(1, 0, 0, 0, dA);
      dutXfers = 0;
      guard = 0;
      while (expQ.size() > 0 && guard < 200) begin
         applyStimulus(0, 0, 1'($urandom_range(0, 1)), 0, '0);
         guard++;
      end
      checkOutput("stall_xfers", 64'(dutXfers), 64'd8);

      $display("[TB] overrun");
      applyStimulus(1, 0, 1, 0, dA);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '0);
      applyStimulus(1, 1, 1, 0, dB);
      checkOutput("ovr_set", 64'(overrun_o), 64'd1);
      applyStimulus(0, 0, 1, 1, '0);
      checkOutput("ovr_clr", 64'(overrun_o), 64'd0);
      applyStimulus(1, 0, 1, 1, dB);
      checkOutput("ovr_setwins", 64'(overrun_o), 64'd1);

      $display("[TB] back-to-back capture");
      guard = 0;
      while (expQ.size() > 1 && guard < 20) begin
         applyStimulus(0, 0, 1, 0, '0);
         guard++;
      end
      applyStimulus(1, 0, 1, 1, dB);
      checkOutput("b2b_valid", 64'(out_valid_o), 64'd1);
      checkOutput("b2b_beat0", 64'(out_data_o), 64'h0000_0000_0201_0200);

      $display("[TB] async reset mid-drain");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, '0);
      rst_n = 1'b0;
      #1;
      expQ.delete();
      modelOverrun = 0;
      checkOutput("arst_valid", 64'(out_valid_o), 64'd0);
      checkOutput("arst_busy", 64'(busy_o), 64'd0);
      checkOutput("arst_last", 64'(out_last_o), 64'd0);
      checkOutput("arst_data", 64'(out_data_o), 64'd0);
      checkOutput("arst_overrun", 64'(overrun_o), 64'd0);
      #3 rst_n = 1'b1;
      applyStimulus(0, 0, 1, 0, '0);
      applyStimulus(1, 0, 1, 0, dA);
      checkOutput("post_rst_beat0", 64'(out_data_o), 64'h0000_0000_0101_0100);

      $display("[TB] randomized run");
      for (int i = 0; i < 600; i++) begin
         logic [N*WD-1:0] rd;
         for (int w = 0; w < N*WD/32; w++) rd[w*32 +: 32] = $urandom;
         applyStimulus(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
